// File: rtl/multi_channel_readout.sv
// Multi-channel byte serializer: streams DEPTH words from each enabled channel,
// interleaved in ascending channel order, MSB byte first, with an optional header.
//
// state  | meaning
// IDLE   | waiting for every enabled channel to be ready
// HEADER | offering 0xA5 then the latched channel mask
// STREAM | offering channel word bytes
// DONE   | one-cycle FrameDone pulse, then back to IDLE
module multi_channel_readout #(
   parameter int NUM_CHANNELS = 4,
   parameter int WORD_WIDTH   = 16,
   parameter int DEPTH        = 512,
   parameter int HEADER_EN    = 0
) (
   input  logic                               Clock,
   input  logic                               Reset,
   input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] ChannelData,
   input  logic [NUM_CHANNELS-1:0]            ChannelReady,
   input  logic [NUM_CHANNELS-1:0]            ChannelEnable,
   output logic [NUM_CHANNELS-1:0]            ChannelRead,
   input  logic                               ReadEnable,
   input  logic                               Abort,
   output logic [7:0]                         DataOut,
   output logic                               DataValid,
   output logic                               FrameDone
);

   localparam int BYTES = WORD_WIDTH / 8;
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int BY_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int WD_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [BY_W-1:0] LAST_BYTE = BY_W'(BYTES - 1);
   localparam logic [WD_W-1:0] LAST_WORD = WD_W'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_STREAM, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [NUM_CHANNELS-1:0] mask_q, mask_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [BY_W-1:0]         byte_q, byte_d;
   logic [WD_W-1:0]         word_q, word_d;
   logic                    hdr_q, hdr_d;
   logic [NUM_CHANNELS-1:0] chan_read_q, chan_read_d;

   logic                    start_ok;
   logic                    higher_found;
   logic [CH_W-1:0]         higher_ch;
   logic [WORD_WIDTH-1:0]   cur_word;
   logic [7:0]              cur_byte;
   int                      byte_shift;

   function automatic logic [CH_W-1:0] lowest_en(input logic [NUM_CHANNELS-1:0] m);
      lowest_en = '0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--)
         if (m[i]) lowest_en = CH_W'(i);
   endfunction

   assign start_ok = (ChannelEnable != '0) &&
                     ((ChannelReady & ChannelEnable) == ChannelEnable);

   // Next enabled channel above the current one; none found means wrap.
   always_comb begin
      higher_found = 1'b0;
      higher_ch    = ch_q;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(ch_q))) begin
            higher_found = 1'b1;
            higher_ch    = CH_W'(i);
         end
      end
   end

   always_comb begin
      cur_word   = ChannelData[int'(ch_q)*WORD_WIDTH +: WORD_WIDTH];
      byte_shift = (BYTES - 1 - int'(byte_q)) * 8;
      cur_byte   = 8'(cur_word >> byte_shift);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         ch_q        <= '0;
         byte_q      <= '0;
         word_q      <= '0;
         hdr_q       <= 1'b0;
         chan_read_q <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         ch_q        <= ch_d;
         byte_q      <= byte_d;
         word_q      <= word_d;
         hdr_q       <= hdr_d;
         chan_read_q <= chan_read_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      ch_d        = ch_q;
      byte_d      = byte_q;
      word_d      = word_q;
      hdr_d       = hdr_q;
      chan_read_d = '0;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               mask_d  = ChannelEnable;
               ch_d    = lowest_en(ChannelEnable);
               byte_d  = '0;
               word_d  = '0;
               hdr_d   = 1'b0;
               state_d = (HEADER_EN != 0) ? S_HEADER : S_STREAM;
            end
         end
         S_HEADER: begin
            if (ReadEnable) begin
               if (hdr_q) begin
                  hdr_d   = 1'b0;
                  state_d = S_STREAM;
               end else begin
                  hdr_d = 1'b1;
               end
            end
         end
         S_STREAM: begin
            if (ReadEnable) begin
               if (byte_q == LAST_BYTE) begin
                  byte_d = '0;
                  for (int i = 0; i < NUM_CHANNELS; i++)
                     chan_read_d[i] = (int'(ch_q) == i);
                  if (higher_found) begin
                     ch_d = higher_ch;
                  end else if (word_q == LAST_WORD) begin
                     state_d = S_DONE;
                  end else begin
                     ch_d   = lowest_en(mask_q);
                     word_d = word_q + WD_W'(1);
                  end
               end else begin
                  byte_d = byte_q + BY_W'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort still lets a just-completed word's pop pulse through.
      if (Abort) begin
         state_d = S_IDLE;
         mask_d  = '0;
         ch_d    = '0;
         byte_d  = '0;
         word_d  = '0;
         hdr_d   = 1'b0;
      end
   end

   always_comb begin
      DataValid = 1'b0;
      DataOut   = 8'h00;
      FrameDone = 1'b0;
      case (state_q)
         S_HEADER: begin
            DataValid = 1'b1;
            DataOut   = hdr_q ? 8'(mask_q) : 8'hA5;
         end
         S_STREAM: begin
            DataValid = 1'b1;
            DataOut   = cur_byte;
         end
         S_DONE:  FrameDone = 1'b1;
         default: ;
      endcase
   end

   assign ChannelRead = chan_read_q;

endmodule

// File: doc/multi_channel_readout.md
MULTI_CHANNEL_READOUT -- requirements
Module: multi_channel_readout

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 4, meaning the number of channel sources (legal range 1..8).
REQ-002 The block SHALL have parameter WORD_WIDTH, default 16, meaning the bits per channel word (multiple of 8, range 8..64).
REQ-003 The block SHALL have parameter DEPTH, default 512, meaning the words read per enabled channel per frame (>=1).
REQ-004 The block SHALL have parameter HEADER_EN, default 0, meaning that 1 prepends a 2-byte frame header.
REQ-005 The block SHALL have port Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port ChannelData, input, NUM_CHANNELS*WORD_WIDTH bits: channel c occupies bits [c*WORD_WIDTH +: WORD_WIDTH].
REQ-008 The block SHALL have port ChannelReady, input, NUM_CHANNELS bits: channel c has a full frame available.
REQ-009 The block SHALL have port ChannelEnable, input, NUM_CHANNELS bits: the mask of channels to transmit, sampled at frame start.
REQ-010 The block SHALL have port ChannelRead, output, NUM_CHANNELS bits: a 1-cycle pulse that pops the current word of channel c.
REQ-011 The block SHALL have port ReadEnable, input, 1 bit: the consumer accepts the byte on DataOut in this cycle.
REQ-012 The block SHALL have port Abort, input, 1 bit: terminates the current frame.
REQ-013 The block SHALL have port DataOut, output, 8 bits: the byte currently offered.
REQ-014 The block SHALL have port DataValid, output, 1 bit: DataOut holds a valid byte.
REQ-015 The block SHALL have port FrameDone, output, 1 bit: a 1-cycle pulse after the final byte of a frame is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, HEADER, STREAM and DONE, all registered.
REQ-017 In IDLE, the block SHALL latch ChannelEnable into an internal mask when (ChannelReady & ChannelEnable) == ChannelEnable and ChannelEnable != 0, then go to HEADER if HEADER_EN=1, else to STREAM.
REQ-018 When ChannelEnable == 0, the block SHALL remain in IDLE indefinitely, with no outputs asserted.
REQ-019 A byte SHALL be accepted on any cycle in which DataValid=1 and ReadEnable=1; the next byte SHALL appear on DataOut in the following cycle; with ReadEnable=0, DataOut and all pointers SHALL hold.
REQ-020 DataValid SHALL be 1 exactly in HEADER and STREAM, and SHALL go high the cycle after the IDLE exit is decided.
REQ-021 HEADER SHALL emit 0xA5 followed by the latched mask, zero-extended to 8 bits, then go to STREAM.
REQ-022 STREAM SHALL visit enabled channels only, in ascending index order, and wrap from the highest enabled channel to the lowest.
REQ-023 Each word SHALL be sent MSB byte first as WORD_WIDTH/8 bytes, taken from ChannelData of the current channel at the time each byte is presented.
REQ-024 ChannelRead[c] SHALL pulse for exactly one cycle, in the cycle after the last byte of channel c's word is accepted; at most one bit SHALL be set at a time.
REQ-025 A word counter SHALL increment after each full pass over the enabled channels.
REQ-026 When the last byte of word DEPTH-1 of the highest enabled channel is accepted, the FSM SHALL go to DONE; total bytes per frame = popcount(mask)*DEPTH*WORD_WIDTH/8 + 2*HEADER_EN.
REQ-027 DONE SHALL pulse FrameDone for one cycle, then return to IDLE.
REQ-028 A new frame SHALL NOT start earlier than the cycle after DONE.
REQ-029 Changes on ChannelEnable mid-frame SHALL be ignored.
REQ-030 Deassertion of ChannelReady mid-frame SHALL be ignored; the source guarantees DEPTH words.
REQ-031 Abort=1 in any state SHALL force IDLE on the next edge, clearing pointers and counters, with no FrameDone and no further ChannelRead pulses; when Abort coincides with an accepted last byte of a word, the ChannelRead pulse for that word SHALL still be issued.
REQ-032 When Reset and Abort are asserted together, Reset SHALL dominate.
REQ-033 Counter widths SHALL be derived via $clog2 from DEPTH, NUM_CHANNELS and WORD_WIDTH/8, so that no wrap occurs before terminal count.

Reset
REQ-034 On Reset=1, the block SHALL set state=IDLE, DataOut=0x00, DataValid=0, ChannelRead=0, FrameDone=0, mask=0 and all counters=0 at the next edge.
REQ-035 Reset SHALL take effect in any state, including mid-word, and no ChannelRead or FrameDone pulse SHALL follow it.

Verification
REQ-036 Defaults, all channels ready and enabled, ReadEnable=1 constantly, ChannelData = {16'h4444,16'h3333,16'h2222,16'h1111} -> bytes 11,11,22,22,33,33,44,44 repeating, 4096 bytes, ChannelRead pulses in order 0,1,2,3, 512 per channel, then one FrameDone.
REQ-037 ChannelEnable=4'b1010, DEPTH=4 -> the stream shows only ch1 then ch3, 16 bytes, and ChannelRead[0] and ChannelRead[2] never pulse.
REQ-038 HEADER_EN=1, mask=4'b0111 -> the first bytes are A5 then 07, then channel data.
REQ-039 ReadEnable toggled randomly (about 30% duty) -> the byte sequence is identical to the REQ-036 case, DataOut is stable while ReadEnable=0, and the ChannelRead count is unchanged.
REQ-040 Abort asserted after byte 5 -> DataValid=0 the next cycle, no FrameDone, and exactly 2 ChannelRead pulses total; a subsequent frame starts cleanly from ch0 byte 0.
REQ-041 WORD_WIDTH=24, NUM_CHANNELS=3, DEPTH=2, with Reset mid-frame then restart -> 3 bytes per word MSB first, and 18 bytes per full frame.
